ic_resp_merge: RTL and testbench

IC_RESP_MERGE -- requirements
Module: ic_resp_merge

---
 rtl/ic_resp_merge.sv | 87 ++++++++
 tb/tb_ic_resp_merge.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ic_resp_merge.sv
// ic_resp_merge: merges boot ROM and L2 fetch responses into one icache grant stream
// Optional feature: define IC_RESP_MERGE_STATS_EN to enable the per-source delivery counters.
// Ports:
//   tb_clk, tb_rstn                  clock, async active-low reset
//   brom_valid_i/brom_data_i         boot ROM response pulse + line (no ready)
//   l2_valid_i/l2_data_i             L2 response pulse + line (no ready)
//   resp_valid_o/resp_data_o/resp_src_o  merged grant (src 0 = boot ROM, 1 = L2)
//   count_o                          queue occupancy
//   overflow_o/drop_cnt_o            sticky drop flag, saturating drop count
//   stat_brom_cnt_o/stat_l2_cnt_o    delivered responses per source
module ic_resp_merge #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                     tb_clk,
  input  logic                     tb_rstn,
  input  logic                     brom_valid_i,
  input  logic [DATA_W-1:0]        brom_data_i,
  input  logic                     l2_valid_i,
  input  logic [DATA_W-1:0]        l2_data_i,
  output logic                     resp_valid_o,
  output logic [DATA_W-1:0]        resp_data_o,
  output logic                     resp_src_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o,
  output logic [15:0]              stat_brom_cnt_o,
  output logic [15:0]              stat_l2_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr, l2_addr;
  logic            pop, acc_b, acc_l;
  logic [CW-1:0]   free;
  logic [1:0]      n_push, n_drop;
  logic [8:0]      drop_sum;
  // A pop at this edge frees its slot for a same-edge push.
  always_comb begin
    pop      = count_o != '0;
    free     = CW'(DEPTH) - count_o + CW'(pop);
    acc_b    = brom_valid_i && free != '0;
    acc_l    = l2_valid_i && free > CW'(acc_b);
    n_push   = 2'(acc_b) + 2'(acc_l);
    n_drop   = 2'(brom_valid_i & ~acc_b) + 2'(l2_valid_i & ~acc_l);
    l2_addr  = acc_b ? wptr + AW'(1) : wptr;
    drop_sum = 9'(drop_cnt_o) + 9'(n_drop);
  end
  always_ff @(posedge tb_clk) begin
    if (tb_rstn && acc_b) mem[wptr] <= {1'b0, brom_data_i};
    if (tb_rstn && acc_l) mem[l2_addr] <= {1'b1, l2_data_i};
  end
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      wptr         <= '0;
      rptr         <= '0;
      count_o      <= '0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_src_o   <= 1'b0;
      overflow_o   <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      wptr         <= wptr + AW'(n_push);
      rptr         <= rptr + AW'(pop);
      count_o      <= count_o + CW'(n_push) - CW'(pop);
      resp_valid_o <= pop;
      if (pop) {resp_src_o, resp_data_o} <= mem[rptr];
      if (n_drop != '0) overflow_o <= 1'b1;
      drop_cnt_o   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`ifdef IC_RESP_MERGE_STATS_EN
  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      stat_brom_cnt_o <= '0;
      stat_l2_cnt_o   <= '0;
    end else if (pop) begin
      if (mem[rptr][DATA_W]) stat_l2_cnt_o <= stat_l2_cnt_o + 16'd1;
      else stat_brom_cnt_o <= stat_brom_cnt_o + 16'd1;
    end
  end
`else
  assign stat_brom_cnt_o = '0;
  assign stat_l2_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_ic_resp_merge.sv
// tb_ic_resp_merge: directed self-checking bench for ic_resp_merge (DEPTH=4, 8-bit data)
module tb_ic_resp_merge;
  logic       tb_clk = 1'b0;
  logic       tb_rstn = 1'b0;
  logic       brom_valid_i = 1'b0, l2_valid_i = 1'b0;
  logic [7:0] brom_data_i = '0, l2_data_i = '0;
  logic       resp_valid_o, resp_src_o, overflow_o;
  logic [7:0] resp_data_o, drop_cnt_o;
  logic [2:0] count_o;
  logic [15:0] stat_brom_cnt_o, stat_l2_cnt_o;
  int pass_cnt = 0, total_cnt = 0;
  logic [8:0] got[$];

  ic_resp_merge #(.DATA_W(8), .DEPTH(4)) dut (
    .tb_clk(tb_clk), .tb_rstn(tb_rstn),
    .brom_valid_i(brom_valid_i), .brom_data_i(brom_data_i),
    .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_src_o(resp_src_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .stat_brom_cnt_o(stat_brom_cnt_o), .stat_l2_cnt_o(stat_l2_cnt_o)
  );

  always #5 tb_clk = ~tb_clk;

  // Drive inputs for one edge, then sample 1 time unit after it and log any grant.
  task automatic step(input logic bv, input logic [7:0] bd, input logic lv, input logic [7:0] ld);
    brom_valid_i = bv; brom_data_i = bd; l2_valid_i = lv; l2_data_i = ld;
    @(posedge tb_clk); #1;
    if (resp_valid_o) got.push_back({resp_src_o, resp_data_o});
  endtask

  task automatic apply_reset();
    tb_rstn = 1'b0; brom_valid_i = 1'b0; l2_valid_i = 1'b0;
    @(posedge tb_clk); #1;
    tb_rstn = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    brom_valid_i = 1'b1; l2_valid_i = 1'b1; brom_data_i = 8'h77; l2_data_i = 8'h88;
    repeat (3) begin @(posedge tb_clk); #1; end
    total_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", resp_valid_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd0) $display("FAIL reset_count got %0d want 0", count_o); else pass_cnt++;
    total_cnt++; if ({resp_src_o, resp_data_o} !== 9'd0) $display("FAIL reset_data got %h want 0", {resp_src_o, resp_data_o}); else pass_cnt++;
    total_cnt++; if ({overflow_o, drop_cnt_o} !== 9'd0) $display("FAIL reset_drop got %h want 0", {overflow_o, drop_cnt_o}); else pass_cnt++;
    brom_valid_i = 1'b0; l2_valid_i = 1'b0;
    tb_rstn = 1'b1;
    step(0, 0, 0, 0);
    total_cnt++; if (count_o !== 3'd0) $display("FAIL reset_ignored_inputs count got %0d want 0", count_o); else pass_cnt++;
  endtask

  task automatic test_single();
    step(1, 8'hA5, 0, 0);
    total_cnt++; if (count_o !== 3'd1 || resp_valid_o !== 1'b0) $display("FAIL single_push count %0d valid %b want 1 0", count_o, resp_valid_o); else pass_cnt++;
    step(0, 0, 0, 0);
    total_cnt++; if ({resp_valid_o, resp_src_o, resp_data_o} !== {1'b1, 1'b0, 8'hA5}) $display("FAIL single_resp got %b %b %h want 1 0 a5", resp_valid_o, resp_src_o, resp_data_o); else pass_cnt++;
    step(0, 0, 0, 0);
    total_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL single_one_cycle valid got %b want 0", resp_valid_o); else pass_cnt++;
    total_cnt++; if ({resp_src_o, resp_data_o} !== {1'b0, 8'hA5}) $display("FAIL single_hold got %b %h want 0 a5", resp_src_o, resp_data_o); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    step(1, 8'h01, 1, 8'h02);
    total_cnt++; if (count_o !== 3'd2) $display("FAIL simul_count2 got %0d want 2", count_o); else pass_cnt++;
    step(0, 0, 0, 0);
    total_cnt++; if ({resp_valid_o, resp_src_o, resp_data_o, count_o} !== {1'b1, 1'b0, 8'h01, 3'd1}) $display("FAIL simul_first got %b %b %h %0d want 1 0 01 1", resp_valid_o, resp_src_o, resp_data_o, count_o); else pass_cnt++;
    step(0, 0, 0, 0);
    total_cnt++; if ({resp_valid_o, resp_src_o, resp_data_o, count_o} !== {1'b1, 1'b1, 8'h02, 3'd0}) $display("FAIL simul_second got %b %b %h %0d want 1 1 02 0", resp_valid_o, resp_src_o, resp_data_o, count_o); else pass_cnt++;
    step(0, 0, 0, 0);
    total_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL simul_end valid got %b want 0", resp_valid_o); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [8:0] exp_q[8];
    exp_q = '{9'h010, 9'h120, 9'h011, 9'h121, 9'h012, 9'h122, 9'h013, 9'h014};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h10 + 8'(k), 1, 8'h20 + 8'(k));
      if (k == 2) begin
        total_cnt++; if (count_o !== 3'd4 || overflow_o !== 1'b0) $display("FAIL ovf_full count %0d ovf %b want 4 0", count_o, overflow_o); else pass_cnt++;
      end
    end
    total_cnt++; if (count_o !== 3'd4) $display("FAIL ovf_count_cap got %0d want 4", count_o); else pass_cnt++;
    repeat (6) step(0, 0, 0, 0);
    total_cnt++; if (got.size() !== 8) $display("FAIL ovf_delivered got %0d want 8", got.size()); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if (k >= got.size()) $display("FAIL ovf_seq%0d got none want %h", k, exp_q[k]);
      else if (got[k] !== exp_q[k]) $display("FAIL ovf_seq%0d got %h want %h", k, got[k], exp_q[k]);
      else pass_cnt++;
    end
    total_cnt++; if ({overflow_o, drop_cnt_o} !== {1'b1, 8'd2}) $display("FAIL ovf_drops got %b %0d want 1 2", overflow_o, drop_cnt_o); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd0) $display("FAIL ovf_drained got %0d want 0", count_o); else pass_cnt++;
  endtask

  task automatic test_saturation();
    apply_reset();
    repeat (257) step(1, 8'h55, 1, 8'h66);
    total_cnt++; if (drop_cnt_o !== 8'd254) $display("FAIL sat_254 got %0d want 254", drop_cnt_o); else pass_cnt++;
    step(1, 8'h55, 1, 8'h66);
    total_cnt++; if (drop_cnt_o !== 8'd255) $display("FAIL sat_255 got %0d want 255", drop_cnt_o); else pass_cnt++;
    repeat (45) step(1, 8'h55, 1, 8'h66);
    total_cnt++; if (drop_cnt_o !== 8'd255) $display("FAIL sat_hold got %0d want 255", drop_cnt_o); else pass_cnt++;
    repeat (6) step(0, 0, 0, 0);
    total_cnt++; if ({overflow_o, drop_cnt_o, count_o} !== {1'b1, 8'd255, 3'd0}) $display("FAIL sat_idle got %b %0d %0d want 1 255 0", overflow_o, drop_cnt_o, count_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(1, 8'hC1, 1, 8'hC2);
    step(1, 8'hC3, 1, 8'hC4);
    total_cnt++; if ({count_o, resp_valid_o} !== {3'd3, 1'b1}) $display("FAIL mid_prep got %0d %b want 3 1", count_o, resp_valid_o); else pass_cnt++;
    brom_valid_i = 1'b0; l2_valid_i = 1'b0;
    #2 tb_rstn = 1'b0;
    #1;
    total_cnt++; if ({resp_valid_o, resp_src_o, resp_data_o, count_o} !== 13'd0) $display("FAIL mid_async got %b %b %h %0d want 0 0 00 0", resp_valid_o, resp_src_o, resp_data_o, count_o); else pass_cnt++;
    @(posedge tb_clk); #1;
    tb_rstn = 1'b1;
    got.delete();
    repeat (6) step(0, 0, 0, 0);
    total_cnt++; if (got.size() !== 0 || count_o !== 3'd0) $display("FAIL mid_stale got %0d resp count %0d want 0 0", got.size(), count_o); else pass_cnt++;
  endtask

  task automatic test_stats();
    logic [15:0] exp_b, exp_l;
`ifdef IC_RESP_MERGE_STATS_EN
    exp_b = 16'd5; exp_l = 16'd7;
`else
    exp_b = 16'd0; exp_l = 16'd0;
`endif
    apply_reset();
    for (int k = 0; k < 5; k++) begin step(1, 8'(k), 0, 0); step(0, 0, 0, 0); end
    for (int k = 0; k < 7; k++) begin step(0, 0, 1, 8'(k)); step(0, 0, 0, 0); end
    repeat (2) step(0, 0, 0, 0);
    total_cnt++; if (got.size() !== 12) $display("FAIL stats_delivered got %0d want 12", got.size()); else pass_cnt++;
    total_cnt++; if (stat_brom_cnt_o !== exp_b) $display("FAIL stats_brom got %0d want %0d", stat_brom_cnt_o, exp_b); else pass_cnt++;
    total_cnt++; if (stat_l2_cnt_o !== exp_l) $display("FAIL stats_l2 got %0d want %0d", stat_l2_cnt_o, exp_l); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_saturation();
    test_reset_mid();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
